// File: rtl/fbrc_pkg.sv
// Shared definitions for the fabric run controller and its counter core.
package fbrc_pkg;

    // Default counter / limit width.
    localparam int CNT_W = 4;

    // Count direction encoding, as seen on cmd_dir and the core's dir input.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } fbrc_state_t;

endpackage : fbrc_pkg

// File: rtl/fbrc_cnt_core.sv
// WIDTH-bit synchronous up/down counter with parallel load.
// Load takes priority over enable; async active-low clear to zero.
module fbrc_cnt_core
    import fbrc_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             dir,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // Counter register: load, else step in the requested direction when enabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else if (ld) begin
            r_q <= ld_val;
        end else if (en) begin
            if (dir == DIR_DOWN) begin
                r_q <= r_q - WIDTH'(1);
            end else begin
                r_q <= r_q + WIDTH'(1);
            end
        end
    end

    assign q = r_q;

endmodule : fbrc_cnt_core

// File: rtl/fbrc_seq_ctrl.sv
// Run controller for the counter core: accepts a count command, sequences
// the run (pause/resume, abort, terminal detection) and reports tc/done.
// The counter core is private to this block; only the controller drives it.
module fbrc_seq_ctrl
    import fbrc_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_limit,
    input  logic             cmd_dir,
    input  logic             cmd_reload,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    fbrc_state_t      r_state;
    fbrc_state_t      w_state_next;

    // Latched command fields, valid from the accept edge until the next accept.
    logic [WIDTH-1:0] r_limit;
    logic             r_dir;
    logic             r_reload;
    logic             r_tc;

    logic             w_accept;
    logic             w_tc_next;
    logic             w_cnt_en;
    logic             w_cnt_ld;
    logic [WIDTH-1:0] w_cnt_ld_val;
    logic [WIDTH-1:0] w_cnt_q;
    logic [WIDTH-1:0] w_start;
    logic [WIDTH-1:0] w_term;
    logic             w_at_term;

    // Accept only in IDLE; cmd_ready is a pure state decode.
    assign w_accept = cmd_valid && (r_state == ST_IDLE);

    // Start and terminal values of the latched run.
    assign w_start   = (r_dir == DIR_DOWN) ? r_limit : '0;
    assign w_term    = (r_dir == DIR_DOWN) ? '0 : r_limit;
    assign w_at_term = (w_cnt_q == w_term);

    // Next-state and counter-control decode. HOLD re-evaluates the same
    // decisions as RUN every edge, so releasing pause steps the counter on
    // that very edge and a pause costs exactly its own length in cycles.
    always_comb begin
        w_state_next = r_state;
        w_cnt_en     = 1'b0;
        w_cnt_ld     = 1'b0;
        w_cnt_ld_val = '0;
        w_tc_next    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_state_next = ST_RUN;
                    w_cnt_ld     = 1'b1;
                    w_cnt_ld_val = (cmd_dir == DIR_DOWN) ? cmd_limit : '0;
                end
            end
            ST_RUN, ST_HOLD: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                    w_cnt_ld     = 1'b1;
                    w_cnt_ld_val = '0;
                end else if (pause) begin
                    w_state_next = ST_HOLD;
                end else if (w_at_term) begin
                    if (r_reload) begin
                        w_state_next = ST_RUN;
                        w_cnt_ld     = 1'b1;
                        w_cnt_ld_val = w_start;
                        w_tc_next    = 1'b1;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end else begin
                    w_state_next = ST_RUN;
                    w_cnt_en     = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register and registered terminal-count pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_tc    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_tc    <= w_tc_next;
        end
    end

    // Command latch, loaded only on the accept edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_limit  <= '0;
            r_dir    <= DIR_UP;
            r_reload <= 1'b0;
        end else if (w_accept) begin
            r_limit  <= cmd_limit;
            r_dir    <= cmd_dir;
            r_reload <= cmd_reload;
        end
    end

    fbrc_cnt_core #(
        .WIDTH (WIDTH)
    ) u_cnt_core (
        .clk    (clk),
        .reset  (reset),
        .en     (w_cnt_en),
        .ld     (w_cnt_ld),
        .ld_val (w_cnt_ld_val),
        .dir    (r_dir),
        .q      (w_cnt_q)
    );

    // Status outputs, all decoded from registers.
    assign out       = w_cnt_q;
    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_RUN) || (r_state == ST_HOLD);
    assign done      = (r_state == ST_DONE);
    assign tc        = r_tc;

endmodule : fbrc_seq_ctrl

// File: tb/tb_fbrc_seq_ctrl.sv
// Self-checking bench for fbrc_seq_ctrl: directed scenarios followed by
// random traffic, every cycle compared against a progress-based model.
module tb_fbrc_seq_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_limit;
    logic         cmd_dir;
    logic         cmd_reload;
    logic         pause;
    logic         abort;
    logic [W-1:0] out;
    logic         busy;
    logic         tc;
    logic         done;

    int n_checks = 0;
    int n_errors = 0;

    // Model: phase 0 idle, 1 counting, 2 frozen, 3 finished.
    // Progress k counts steps taken from the start value; out is derived.
    int m_phase;
    int m_k;
    int m_lim;
    int m_down;
    int m_rel;
    int m_tc;
    int m_idle_out;

    fbrc_seq_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_limit  (cmd_limit),
        .cmd_dir    (cmd_dir),
        .cmd_reload (cmd_reload),
        .pause      (pause),
        .abort      (abort),
        .out        (out),
        .busy       (busy),
        .tc         (tc),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_out();
        if (m_phase == 0) return m_idle_out;
        return (m_down != 0) ? (m_lim - m_k) : m_k;
    endfunction

    task automatic model_reset();
        m_phase    = 0;
        m_k        = 0;
        m_lim      = 0;
        m_down     = 0;
        m_rel      = 0;
        m_tc       = 0;
        m_idle_out = 0;
    endtask

    // One rising edge worth of behaviour, from the inputs currently applied.
    task automatic model_step();
        m_tc = 0;
        case (m_phase)
            0: if (cmd_valid) begin
                m_lim   = int'(cmd_limit);
                m_down  = int'(cmd_dir);
                m_rel   = int'(cmd_reload);
                m_k     = 0;
                m_phase = 1;
            end
            1, 2: begin
                if (abort) begin
                    m_phase    = 0;
                    m_idle_out = 0;
                end else if (pause) begin
                    m_phase = 2;
                end else if (m_k == m_lim) begin
                    if (m_rel != 0) begin
                        m_k  = 0;
                        m_tc = 1;
                    end else begin
                        m_phase = 3;
                    end
                    if (m_phase != 3) m_phase = 1;
                end else begin
                    m_k++;
                    m_phase = 1;
                end
            end
            default: begin
                m_idle_out = (m_down != 0) ? 0 : m_lim;
                m_phase    = 0;
            end
        endcase
    endtask

    task automatic check_outputs();
        check_val("out",       int'(out),       model_out());
        check_val("busy",      int'(busy),      (m_phase == 1 || m_phase == 2) ? 1 : 0);
        check_val("cmd_ready", int'(cmd_ready), (m_phase == 0) ? 1 : 0);
        check_val("tc",        int'(tc),        m_tc);
        check_val("done",      int'(done),      (m_phase == 3) ? 1 : 0);
    endtask

    task automatic set_in(input bit v, input int lim, input bit d, input bit rl,
                          input bit p, input bit a);
        cmd_valid  = v;
        cmd_limit  = W'(lim);
        cmd_dir    = d;
        cmd_reload = rl;
        pause      = p;
        abort      = a;
    endtask

    // Edge, model update, then compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        model_reset();
        #3;
        check_outputs();
        @(negedge clk);
        reset = 1'b1;

        // Reset mid-run: up one-shot L=9, reset when out=4.
        set_in(1, 9, 0, 0, 0, 0); tick();
        set_in(0, 0, 0, 0, 0, 0); ticks(4);
        check_val("mid_out_before_reset", int'(out), 4);
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        reset = 1'b1;

        // Up one-shot L=5.
        set_in(1, 5, 0, 0, 0, 0); tick();
        set_in(0, 0, 0, 0, 0, 0); ticks(8);

        // Down reload L=3, then abort.
        set_in(1, 3, 1, 1, 0, 0); tick();
        set_in(0, 0, 0, 0, 0, 0); ticks(10);
        set_in(0, 0, 0, 0, 0, 1); tick();
        set_in(0, 0, 0, 0, 0, 0); ticks(2);

        // Up one-shot L=9, pause 3 cycles at out=4.
        set_in(1, 9, 0, 0, 0, 0); tick();
        set_in(0, 0, 0, 0, 0, 0); ticks(4);
        set_in(0, 0, 0, 0, 1, 0); ticks(3);
        set_in(0, 0, 0, 0, 0, 0); ticks(5);
        check_val("pause_out_after_edge12", int'(out), 9);
        ticks(1);
        check_val("pause_done_after_edge13", int'(done), 1);
        ticks(2);

        // L=0 one-shot, L=0 reload, L=15 one-shot.
        set_in(1, 0, 0, 0, 0, 0); tick();
        set_in(0, 0, 0, 0, 0, 0); ticks(3);
        set_in(1, 0, 1, 1, 0, 0); tick();
        set_in(0, 0, 0, 0, 0, 0); ticks(4);
        set_in(0, 0, 0, 0, 0, 1); tick();
        set_in(1, 15, 0, 0, 0, 0); tick();
        set_in(0, 0, 0, 0, 0, 0); ticks(18);

        // cmd_valid with L=2 held during a run, then abort on terminal edge.
        set_in(1, 6, 0, 0, 0, 0); tick();
        set_in(1, 2, 1, 1, 0, 0); ticks(6);
        set_in(0, 0, 0, 0, 0, 1); tick();
        set_in(0, 0, 0, 0, 0, 0); ticks(3);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom % 3) == 0, int'($urandom_range(0, 15)),
                   bit'($urandom % 2), ($urandom % 4) == 0,
                   ($urandom % 8) == 0, ($urandom % 40) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fbrc_seq_ctrl

// File: doc/fbrc_seq_ctrl.md
# fbrc_seq_ctrl

Run controller for the team's 4-bit synchronous counter datapath. Accepts a count command (limit, direction, auto-reload) over a valid/ready handshake and sequences the counter: start, pause/resume, abort, terminal-count detection. Reports completion to the surrounding logic. Instantiates the counter core internally and drives its enable/load/direction controls, so no other block touches the counter directly.

## Interface
Parameters:
- `WIDTH`, 4: counter and limit width.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `reset`, in, 1: reset, asynchronous, active-low.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: controller can accept a command. High exactly in IDLE.
- `cmd_limit`, in, WIDTH: terminal limit L, in the range 0..2^WIDTH-1.
- `cmd_dir`, in, 1: count direction. 0 = up, counts 0→L. 1 = down, counts L→0.
- `cmd_reload`, in, 1: 1 = auto-reload, runs until abort. 0 = one-shot.
- `pause`, in, 1: level-sensitive freeze request.
- `abort`, in, 1: level-sensitive cancel.
- `out`, out, WIDTH: current counter value.
- `busy`, out, 1: state is RUN or HOLD.
- `tc`, out, 1: one-cycle pulse on each auto-reload wrap.
- `done`, out, 1: one-cycle pulse on one-shot completion.

## Operation
- Reset (`reset`=0, asynchronous): state=IDLE, `out`=0, `tc`=0, `done`=0, `busy`=0, `cmd_ready`=1.
- Command latch: the command is accepted on an edge where `cmd_valid` and `cmd_ready` are both high.
  - Latch L, dir and reload.
  - `out` ← start value S: S=0 for up, S=L for down.
  - Next state is RUN.
  - Terminal value T: T=L for up, T=0 for down.
- Commands while not IDLE: `cmd_valid` is ignored (`cmd_ready`=0). Command fields matter only on the accept edge.
- States:
  - IDLE
  - RUN
  - HOLD
  - DONE
- RUN: decisions in priority order, evaluated per edge.
  1. `abort`: go to IDLE, `out` ← 0, no `done`, no `tc`.
  2. `pause`: go to HOLD, `out` unchanged.
  3. `out`==T with reload=1: `out` ← S, `tc` ← 1, stay in RUN.
  4. `out`==T with reload=0: go to DONE, `out` holds T.
  5. Otherwise: `out` ← `out`+1 (up) or `out`−1 (down).
- HOLD: `out` frozen.
  - `abort` → IDLE with `out` ← 0.
  - Otherwise `pause`=0 → RUN.
- DONE: `done`=1 for this one cycle, `cmd_ready`=0. Always go to IDLE next edge. `out` holds T until the next accept.
- Arithmetic: `out` never passes T, so there is no modular wrap inside a run. L=2^WIDTH−1 uses the full range.
- `tc` is registered and deasserted on every edge where it is not set.

## Timing
- Accept at edge 0. Edge 1 is the first RUN decision.
- Up one-shot, limit L, no pause:
  - `out`=k after edge k, for k=0..L.
  - Edge L+1 enters DONE; `done` is high for the cycle after edge L+1.
  - Edge L+2 returns to IDLE; `cmd_ready` is high after edge L+2.
- Down one-shot: same cycle count, with values L..0.
- Each pause cycle spent in HOLD delays completion by one cycle. Leaving HOLD costs no extra cycle.
- Auto-reload period is L+1 edges. `tc` is high in the cycle after `out` returns to S.
- L=0:
  - One-shot: DONE is entered at edge 1.
  - Reload: `tc` is high every cycle from edge 1 on, and `out` stays 0.
- Reset asserted mid-run: all outputs take their reset values immediately, with no `done` and no `tc`. The first accept is possible on the first edge after release.
- `busy` and `cmd_ready` are decoded from the registered state: no combinational path from inputs.

## Structure
- Package `fbrc_pkg`:
  - state enum (IDLE, RUN, HOLD, DONE)
  - `CNT_W`=4
  - `DIR_UP`=0, `DIR_DOWN`=1
- Sub-module `fbrc_cnt_core`: WIDTH-bit synchronous counter.
  - Ports `clk`, `reset`, `en`, `ld`, `ld_val`, `dir`, `q`.
  - `ld` has priority over `en`.
  - Async active-low clear to 0.
- The controller owns the FSM, the latched command, terminal compare, and the `tc`/`done` generation.

## Test plan
- Reset mid-run: up one-shot L=9, pull `reset` low when `out`=4 → `out`=0, `busy`=0, `cmd_ready`=1 immediately. No `done` seen.
- Up one-shot L=5 → `out` 0,1,2,3,4,5 on edges 0..5, `done` after edge 6 for exactly 1 cycle, `out` holds 5, `cmd_ready` high after edge 7.
- Down reload L=3 → `out` 3,2,1,0,3,2,…, `tc` pulse every 4 cycles. Then `abort` → IDLE with `out`=0, no `done`.
- Up one-shot L=9, `pause` held 3 cycles while `out`=4 → `out`=4 for 4 cycles total, `done` after edge 13.
- L=0 up one-shot → `done` after edge 1. L=15 up one-shot → `out` reaches 15 with no wrap, `done` after edge 16.
- `cmd_valid` with L=2 held during a run → ignored. `abort` on the same edge as `out`==T (one-shot) → IDLE with `out`=0, `done` stays 0.
